// File: rtl/mdu_divider_pkg.sv
// Shared MDU definitions: ALU op codes for the multiply/divide group and the
// divider state encoding. Imported by the ALU decode and by mdu_divider.
package mdu_divider_pkg;

  localparam logic [5:0] OP_MUL    = 6'b001000;
  localparam logic [5:0] OP_MULH   = 6'b001001;
  localparam logic [5:0] OP_MULHSU = 6'b001010;
  localparam logic [5:0] OP_MULHU  = 6'b001011;
  localparam logic [5:0] OP_DIV    = 6'b001100;
  localparam logic [5:0] OP_DIVU   = 6'b001101;
  localparam logic [5:0] OP_REM    = 6'b001110;
  localparam logic [5:0] OP_REMU   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // The four divide/remainder codes share the upper nibble 4'b0011
  function automatic logic is_div_op(input logic [5:0] sel);
    return sel[5:2] == 4'b0011;
  endfunction

  // DIV and REM are the signed flavours (low bit clear)
  function automatic logic is_signed_op(input logic [5:0] sel);
    return (sel == OP_DIV) || (sel == OP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic is_rem_op(input logic [5:0] sel);
    return (sel == OP_REM) || (sel == OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_divider_div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference only
// when it did not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] partial;
  logic [XLEN+1:0] diff;

  // Trial subtraction one bit wider than the partial remainder so the top bit is a clean borrow
  always_comb begin
    partial = {rem_in, dividend_bit};
    diff    = partial - {2'b00, divisor};
    q_bit   = ~diff[XLEN+1];
    rem_out = q_bit ? diff[XLEN:0] : partial[XLEN:0];
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative integer divider for the MDU: DIV/DIVU/REM/REMU, one quotient bit
// per clock. Signed ops divide magnitudes and fix the sign on the last step.
// Divide-by-zero and signed overflow can bypass the iteration entirely.
module mdu_divider
  import mdu_divider_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [5:0]      select,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

  div_state_e      state;
  logic [5:0]      count;
  logic [XLEN:0]   rem_reg;
  logic [XLEN-1:0] quo_reg;
  logic [XLEN-1:0] divisor_reg;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;

  logic            accept;
  logic            sgn_op;
  logic            rem_sel;
  logic            in_zero;
  logic            in_ovf;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] early_res;

  logic [XLEN:0]   step_rem;
  logic            step_q;
  logic [XLEN-1:0] final_q;
  logic [XLEN-1:0] final_r;
  logic [XLEN-1:0] final_res;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in       (rem_reg),
    .dividend_bit (quo_reg[XLEN-1]),
    .divisor      (divisor_reg),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Decode the incoming request: acceptance, operand magnitudes and the special cases
  always_comb begin
    sgn_op    = is_signed_op(select);
    rem_sel   = is_rem_op(select);
    accept    = (state == ST_IDLE) && start && !flush && is_div_op(select);
    mag1      = (sgn_op && data1[XLEN-1]) ? -data1 : data1;
    mag2      = (sgn_op && data2[XLEN-1]) ? -data2 : data2;
    in_zero   = (data2 == '0);
    in_ovf    = sgn_op && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
    early_res = in_zero ? (rem_sel ? data1 : '1) : (rem_sel ? '0 : data1);
  end

  // Sign-correct the outcome of the final iteration so it can be registered on the same edge
  always_comb begin
    final_q   = {quo_reg[XLEN-2:0], step_q};
    final_r   = step_rem[XLEN-1:0];
    final_res = op_rem ? (neg_r ? -final_r : final_r)
                       : (neg_q ? -final_q : final_q);
  end

  // Divider FSM with datapath registers; flush abandons work but keeps the last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      op_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      valid       <= 1'b0;
      result      <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          valid <= 1'b0;
          if (accept) begin
            // A zero divisor leaves the quotient unsigned (all ones) and the remainder equal to the dividend
            op_rem      <= rem_sel;
            neg_q       <= sgn_op && (data1[XLEN-1] ^ data2[XLEN-1]) && !in_zero;
            neg_r       <= sgn_op && data1[XLEN-1];
            quo_reg     <= mag1;
            divisor_reg <= mag2;
            rem_reg     <= '0;
            count       <= '0;
            if (EARLY_OUT && (in_zero || in_ovf)) begin
              state  <= ST_DONE;
              valid  <= 1'b1;
              result <= early_res;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          quo_reg <= final_q;
          rem_reg <= step_rem;
          count   <= count + 6'd1;
          if (count == LAST_ITER) begin
            state  <= ST_DONE;
            valid  <= 1'b1;
            result <= final_res;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          valid <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed vector table, randomized ops
// against an arithmetic reference, and hand-written flush/reset/back-pressure sequences.
module tb_mdu_divider;
  import mdu_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [5:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  mdu_divider #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .select (select),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic plus the architectural special cases
  function automatic logic [31:0] refResult(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic sgn;
    logic rem;
    sa  = a;
    sb  = b;
    sgn = (op == OP_DIV) || (op == OP_REM);
    rem = (op == OP_REM) || (op == OP_REMU);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
    return rem ? a % b : a / b;
  endfunction

  // Special cases finish one cycle after the start cycle, everything else after 33
  function automatic int refLatency(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'd0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one request and wait (bounded) for the VALID pulse
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat, output int busy_cycles,
                               output logic seen);
    select      = op;
    data1       = a;
    data2       = b;
    start       = 1'b1;
    lat         = 0;
    busy_cycles = 0;
    seen        = 1'b0;
    res         = '0;
    while (!seen && lat < 100) begin
      tick();
      lat++;
      start = 1'b0;
      if (busy) busy_cycles++;
      if (valid) begin
        seen = 1'b1;
        res  = result;
      end
    end
  endtask

  task automatic runCheck(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    int          bcyc;
    logic        seen;
    applyStimulus(op, a, b, res, lat, bcyc, seen);
    checkOutput($sformatf("%s valid seen", name), 32'(seen), 32'd1);
    checkOutput($sformatf("%s result", name), res, exp_res);
    checkOutput($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
    checkOutput($sformatf("%s busy cycles", name), 32'(bcyc), 32'(exp_lat));
    tick();
    checkOutput($sformatf("%s idle after done", name), {30'd0, valid, busy}, 32'd0);
  endtask

  task automatic countValid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (valid) n++;
    end
  endtask

  initial begin
    vec_t        vecs[14];
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          bcyc;
    int          nvalid;
    logic        seen;

    vecs[0]  = '{"div 7/2",          OP_DIV,  32'd7,          32'd2,          32'd3,          33};
    vecs[1]  = '{"rem -7/2",         OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[2]  = '{"divu ffffffff/10", OP_DIVU, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  33};
    vecs[3]  = '{"remu ffffffff/10", OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          33};
    vecs[4]  = '{"div 5/0",          OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{"rem 5/0",          OP_REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{"div overflow",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[7]  = '{"rem overflow",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[8]  = '{"divu 5/0",         OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[9]  = '{"remu big/ones",    OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};
    vecs[10] = '{"div -7/2",         OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[11] = '{"div 100/-7",       OP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33};
    vecs[12] = '{"rem 100/-7",       OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          33};
    vecs[13] = '{"rem -8/0",         OP_REM,  32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  1};

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    select = 6'd0;
    data1  = 32'd0;
    data2  = 32'd0;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++)
      runCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    // A multiply code on START must be ignored
    select = OP_MUL;
    data1  = 32'd6;
    data2  = 32'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("mul code ignored busy", 32'(busy), 32'd0);
    countValid(3, nvalid);
    checkOutput("mul code no valid", 32'(nvalid), 32'd0);

    // Randomized ops against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      op = OP_DIV + 6'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      runCheck($sformatf("rand%0d op%0h", i, op), op, a, b, refResult(op, a, b), refLatency(op, a, b));
    end

    // Flush at iteration 10 abandons the op and keeps the previous result
    runCheck("div 20/4", OP_DIV, 32'd20, 32'd4, 32'd5, 33);
    select = OP_DIV;
    data1  = 32'd1000;
    data2  = 32'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("flush seq accepted", 32'(busy), 32'd1);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush busy", 32'(busy), 32'd0);
    checkOutput("flush valid", 32'(valid), 32'd0);
    checkOutput("flush result kept", result, 32'd5);
    countValid(40, nvalid);
    checkOutput("flush no later valid", 32'(nvalid), 32'd0);
    runCheck("div 9/3 after flush", OP_DIV, 32'd9, 32'd3, 32'd3, 33);

    // START held through BUSY and DONE with other operands is ignored
    select = OP_DIV;
    data1  = 32'd100;
    data2  = 32'd10;
    start  = 1'b1;
    tick();
    select = OP_REM;
    data1  = 32'd77;
    data2  = 32'd5;
    lat    = 1;
    seen   = valid;
    while (!seen && lat < 100) begin
      tick();
      lat++;
      if (valid) seen = 1'b1;
    end
    checkOutput("busy start valid seen", 32'(seen), 32'd1);
    checkOutput("busy start latency", 32'(lat), 32'd33);
    checkOutput("busy start result", result, 32'd10);
    tick();
    start = 1'b0;
    checkOutput("start in done ignored", {30'd0, valid, busy}, 32'd0);
    countValid(40, nvalid);
    checkOutput("no second result", 32'(nvalid), 32'd0);

    // FLUSH beats a simultaneous START in IDLE
    select = OP_DIVU;
    data1  = 32'd10;
    data2  = 32'd2;
    start  = 1'b1;
    flush  = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    checkOutput("flush over start busy", 32'(busy), 32'd0);
    countValid(3, nvalid);
    checkOutput("flush over start no valid", 32'(nvalid), 32'd0);

    // Asynchronous reset at iteration 20
    select = OP_DIV;
    data1  = 32'd1000;
    data2  = 32'd3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset valid", 32'(valid), 32'd0);
    checkOutput("async reset result", result, 32'd0);
    tick();
    #3;
    rst_n = 1'b1;
    countValid(40, nvalid);
    checkOutput("no valid after reset", 32'(nvalid), 32'd0);
    checkOutput("idle after reset", 32'(busy), 32'd0);
    runCheck("divu after reset", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
MDU_DIVIDER -- requirements
Module: mdu_divider

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 Parameter EARLY_OUT, default 1: when 1, divide-by-zero and signed-overflow cases complete without iterating.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request strobe from the EX stage; sampled only in IDLE.
REQ-006 SELECT  input  6  ALU op code; 6'b001100 DIV, 6'b001101 DIVU, 6'b001110 REM, 6'b001111 REMU.
REQ-007 DATA1  input  XLEN  dividend.
REQ-008 DATA2  input  XLEN  divisor.
REQ-009 FLUSH  input  1  pipeline kill; abandons any in-flight operation.
REQ-010 BUSY  output  1  high in any state other than IDLE; the EX stage stalls on it.
REQ-011 VALID  output  1  one-cycle pulse marking RESULT valid.
REQ-012 RESULT  output  XLEN  quotient or remainder, held until the next START is accepted.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE only.
REQ-014 IDLE->BUSY on an edge with START=1, SELECT a div/rem code and FLUSH=0; operands, op and signs SHALL be latched on that edge.
REQ-015 START with a non-div/rem SELECT SHALL be ignored (no state change, VALID stays 0).
REQ-016 Signed ops SHALL divide operand magnitudes and then correct signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-017 Core SHALL be radix-2 restoring, one quotient bit per cycle, with a 6-bit iteration counter and an XLEN+1-bit partial remainder.
REQ-018 Normal path: BUSY holds for exactly XLEN edges after the accept edge, then moves to DONE; VALID=1 during DONE, which lasts one cycle, then IDLE. Accept at edge k gives VALID high after edge k+XLEN+1.
REQ-019 Divide by zero (DATA2=0) SHALL return: DIV/DIVU all ones; REM/REMU DATA1.
REQ-020 Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF) SHALL return: DIV 0x80000000; REM 0.
REQ-021 With EARLY_OUT=1, REQ-019/020 cases SHALL go IDLE->DONE directly: VALID after edge k+1.
REQ-022 START while BUSY or DONE SHALL be ignored; there is no queueing.
REQ-023 FLUSH=1 on any edge SHALL force IDLE, suppress VALID and leave RESULT unchanged; FLUSH overrides a simultaneous START.
REQ-024 START in the same cycle as DONE SHALL be ignored; a new op is accepted from the IDLE cycle that follows.

Reset
REQ-025 RESET=0 SHALL immediately force IDLE, BUSY=0, VALID=0, RESULT=0 and clear counter and partial remainder, regardless of the clock.
REQ-026 Reset mid-operation SHALL discard the operation; no VALID follows reset release.

Structure
REQ-027 Shared package holds the op-code constants (DIV, DIVU, REM, REMU, plus the MUL codes 6'b001000-001011) and the state enum; the ALU and this block both import it.
REQ-028 One sub-module, div_step: combinational single-iteration subtract/restore; no other hierarchy.

Verification
REQ-029 DIV 7 / 2 -> RESULT=3, VALID exactly 33 cycles after accept, BUSY high for 33 cycles; REM -7 / 2 -> 0xFFFFFFFF.
REQ-030 DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; REMU same operands -> 0xF.
REQ-031 DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, VALID 1 cycle after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-032 FLUSH at iteration 10 -> no VALID, IDLE next cycle; a following DIV 9 / 3 returns 3.
REQ-033 Second START during BUSY with different operands -> ignored, first result delivered unchanged.
REQ-034 RESET low at iteration 20 -> BUSY=0, VALID=0, RESULT=0 immediately (asynchronously); no VALID after release.
